// File: rtl/test_vector_sequencer.sv
// Stimulus/checker engine for a combinational DUT. It applies stored vectors one at a time,
// samples the DUT result a cycle later, and records the pass/fail status and the first failure.
module test_vector_sequencer #(
   parameter int unsigned IN_W  = 3,
   parameter int unsigned OUT_W = 1,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  stop_on_fail,
   input  logic [AW:0]           num_vectors,
   input  logic                  load_we,
   input  logic [AW-1:0]         load_addr,
   input  logic [IN_W+OUT_W-1:0] load_data,
   output logic [IN_W-1:0]       dut_in,
   input  logic [OUT_W-1:0]      dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [AW:0]           err_count,
   output logic [AW-1:0]         vec_num,
   output logic                  fail_valid,
   output logic [AW-1:0]         fail_vec,
   output logic [OUT_W-1:0]      fail_got
);

   localparam int unsigned VW = IN_W + OUT_W;
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DepthC = CW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

   state_e            state_q, state_d;
   logic [VW-1:0]     mem [DEPTH];
   logic [CW-1:0]     n_q, n_d;
   logic              sof_q, sof_d;
   logic [OUT_W-1:0]  exp_q, exp_d;
   logic [IN_W-1:0]   din_q, din_d;
   logic [CW-1:0]     err_q, err_d;
   logic [AW-1:0]     vec_q, vec_d;
   logic              fv_q, fv_d;
   logic [AW-1:0]     fvec_q, fvec_d;
   logic [OUT_W-1:0]  fgot_q, fgot_d;
   logic              idle_or_done;
   logic              mismatch;
   logic              last_vec;
   logic [CW-1:0]     eff_n;

   assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
   // Case inequality so an X from the DUT counts as a mismatch in simulation; synthesises as !=.
   assign mismatch     = (dut_out !== exp_q);
   assign last_vec     = ({1'b0, vec_q} == (n_q - CW'(1)));
   assign eff_n        = (num_vectors > DepthC) ? DepthC : num_vectors;

   // Vector memory: single write port, locked while a run is in progress, never reset.
   always_ff @(posedge clk) begin
      if (load_we && idle_or_done) begin
         mem[load_addr] <= load_data;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sof_d   = sof_q;
      exp_d   = exp_q;
      din_d   = din_q;
      err_d   = err_q;
      vec_d   = vec_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      fgot_d  = fgot_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               n_d     = eff_n;
               sof_d   = stop_on_fail;
               err_d   = '0;
               vec_d   = '0;
               fv_d    = 1'b0;
               fvec_d  = '0;
               fgot_d  = '0;
               state_d = (eff_n == '0) ? StDone : StApply;
            end
         end
         StApply: begin
            din_d   = mem[vec_q][VW-1:OUT_W];
            exp_d   = mem[vec_q][OUT_W-1:0];
            state_d = StCheck;
         end
         StCheck: begin
            if (mismatch) begin
               if (err_q != '1) begin
                  err_d = err_q + CW'(1);
               end
               if (!fv_q) begin
                  fv_d   = 1'b1;
                  fvec_d = vec_q;
                  fgot_d = dut_out;
               end
            end
            if ((mismatch && sof_q) || last_vec) begin
               state_d = StDone;
            end else begin
               vec_d   = vec_q + AW'(1);
               state_d = StApply;
            end
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         n_q    <= '0;
         sof_q  <= 1'b0;
         exp_q  <= '0;
         din_q  <= '0;
         err_q  <= '0;
         vec_q  <= '0;
         fv_q   <= 1'b0;
         fvec_q <= '0;
         fgot_q <= '0;
      end else begin
         n_q    <= n_d;
         sof_q  <= sof_d;
         exp_q  <= exp_d;
         din_q  <= din_d;
         err_q  <= err_d;
         vec_q  <= vec_d;
         fv_q   <= fv_d;
         fvec_q <= fvec_d;
         fgot_q <= fgot_d;
      end
   end

   // Status outputs decode directly from the state register.
   always_comb begin
      busy = (state_q == StApply) || (state_q == StCheck);
      done = (state_q == StDone);
      pass = (state_q == StDone) && (err_q == '0);
   end

   assign dut_in     = din_q;
   assign err_count  = err_q;
   assign vec_num    = vec_q;
   assign fail_valid = fv_q;
   assign fail_vec   = fvec_q;
   assign fail_got   = fgot_q;

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Directed bench: one instance drives sillyfunction (3 inputs), a second drives xorfour (4 inputs).
module tb_test_vector_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // sillyfunction instance
   logic       s_start, s_sof, s_we, s_dout, s_busy, s_done, s_pass, s_fv, s_fgot;
   logic [4:0] s_nv, s_err;
   logic [3:0] s_addr, s_data, s_vec, s_fvec;
   logic [2:0] s_din;

   assign s_dout = (~s_din[1] & ~s_din[0]) | (s_din[2] & ~s_din[1]);

   test_vector_sequencer #(.IN_W(3), .OUT_W(1), .DEPTH(16), .AW(4)) u_silly (
      .clk(clk), .reset(reset), .start(s_start), .stop_on_fail(s_sof), .num_vectors(s_nv),
      .load_we(s_we), .load_addr(s_addr), .load_data(s_data), .dut_in(s_din),
      .dut_out(s_dout), .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
      .vec_num(s_vec), .fail_valid(s_fv), .fail_vec(s_fvec), .fail_got(s_fgot)
   );

   // xorfour instance
   logic       x_start, x_sof, x_we, x_dout, x_busy, x_done, x_pass, x_fv, x_fgot;
   logic [4:0] x_nv, x_err, x_data;
   logic [3:0] x_addr, x_vec, x_fvec, x_din;

   assign x_dout = ^x_din;

   test_vector_sequencer #(.IN_W(4), .OUT_W(1), .DEPTH(16), .AW(4)) u_xor (
      .clk(clk), .reset(reset), .start(x_start), .stop_on_fail(x_sof), .num_vectors(x_nv),
      .load_we(x_we), .load_addr(x_addr), .load_data(x_data), .dut_in(x_din),
      .dut_out(x_dout), .busy(x_busy), .done(x_done), .pass(x_pass), .err_count(x_err),
      .vec_num(x_vec), .fail_valid(x_fv), .fail_vec(x_fvec), .fail_got(x_fgot)
   );

   int checks = 0;
   int errors = 0;
   int dc, nb;
   logic found;
   logic [3:0] good [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b0110,
                            4'b1001, 4'b1011, 4'b1100, 4'b1110};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_s(input logic [3:0] a, input logic [3:0] d);
      s_we = 1'b1; s_addr = a; s_data = d;
      @(posedge clk); #1;
      s_we = 1'b0;
   endtask

   task automatic load_good();
      for (int i = 0; i < 8; i++) load_s(4'(i), good[i]);
   endtask

   // Caller's current cycle is cycle 0; returns the cycle done first seen and busy-cycle count.
   task automatic run_s(input int nv, input logic sof, output int dcyc, output int nbusy);
      s_nv = nv[4:0]; s_sof = sof; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      dcyc = -1; nbusy = 0;
      for (int c = 1; c < 100; c++) begin
         @(negedge clk);
         if (s_done) begin
            dcyc = c;
            break;
         end
         if (s_busy) nbusy++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b1;
      s_start = 0; s_sof = 0; s_nv = 0; s_we = 0; s_addr = 0; s_data = 0;
      x_start = 0; x_sof = 0; x_nv = 0; x_we = 0; x_addr = 0; x_data = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      chk("reset_outs", {s_busy, s_done, s_pass, s_err, s_vec, s_fv, s_fvec, s_fgot}, 0);
      chk("reset_din", s_din, 0);

      // num_vectors = 0 finishes immediately without touching dut_in
      run_s(0, 1'b0, dc, nb);
      chk("n0_done_cycle", dc, 1);
      chk("n0_busy", nb, 0);
      chk("n0_pass", s_pass, 1);
      chk("n0_din", s_din, 0);

      // Test 1: clean run
      load_good();
      run_s(8, 1'b0, dc, nb);
      chk("t1_done_cycle", dc, 17);
      chk("t1_busy_cycles", nb, 16);
      chk("t1_pass", s_pass, 1);
      chk("t1_err", s_err, 0);
      chk("t1_fail_valid", s_fv, 0);
      chk("t1_din", s_din, 3'b111);

      // Test 2: entry 5 corrupted, run to the end (restarted from DONE)
      load_s(4'd5, 4'b1010);
      run_s(8, 1'b0, dc, nb);
      chk("t2_done_cycle", dc, 17);
      chk("t2_err", s_err, 1);
      chk("t2_fail_valid", s_fv, 1);
      chk("t2_fail_vec", s_fvec, 5);
      chk("t2_fail_got", s_fgot, 1);
      chk("t2_pass", s_pass, 0);
      chk("t2_vec", s_vec, 7);

      // Test 3: entries 2 and 5 corrupted, stop at first failure
      load_s(4'd2, 4'b0101);
      run_s(8, 1'b1, dc, nb);
      chk("t3_done_cycle", dc, 7);
      chk("t3_err", s_err, 1);
      chk("t3_fail_vec", s_fvec, 2);
      chk("t3_fail_got", s_fgot, 0);
      chk("t3_vec", s_vec, 2);
      chk("t3_din", s_din, 3'b010);
      chk("t3_pass", s_pass, 0);

      // Test 4: xorfour, num_vectors=20 clamps to 16
      for (int i = 0; i < 16; i++) begin
         x_we = 1'b1; x_addr = 4'(i); x_data = {4'(i), ^(4'(i))};
         @(posedge clk); #1;
      end
      x_we = 1'b0;
      x_nv = 5'd20; x_start = 1'b1;
      @(posedge clk); #1;
      x_start = 1'b0;
      dc = -1; nb = 0;
      for (int c = 1; c < 100; c++) begin
         @(negedge clk);
         if (x_done) begin
            dc = c;
            break;
         end
         if (x_busy) nb++;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("t4_done_cycle", dc, 33);
      chk("t4_busy_cycles", nb, 32);
      chk("t4_pass", x_pass, 1);
      chk("t4_vec", x_vec, 15);
      chk("t4_din", x_din, 4'hf);

      // Test 5: reset mid-run, memory retained
      load_good();
      s_nv = 5'd8; s_sof = 1'b0; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (s_vec == 4'd3) begin
            found = 1'b1;
            break;
         end
      end
      chk("t5_reached_vec3", found, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      chk("t5_reset_outs", {s_busy, s_done, s_pass, s_err, s_vec, s_fv, s_fvec, s_fgot}, 0);
      chk("t5_reset_din", s_din, 0);
      run_s(8, 1'b0, dc, nb);
      chk("t5_done_cycle", dc, 17);
      chk("t5_pass", s_pass, 1);

      // Test 6: load and start during a run are ignored
      s_nv = 5'd8; s_sof = 1'b0; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      s_we = 1'b1; s_addr = 4'd7; s_data = 4'b1111; s_start = 1'b1;
      @(posedge clk); #1;
      s_we = 1'b0; s_start = 1'b0;
      dc = -1;
      for (int c = 4; c < 100; c++) begin
         @(negedge clk);
         if (s_done) begin
            dc = c;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      chk("t6_done_cycle", dc, 17);
      chk("t6_pass", s_pass, 1);
      chk("t6_err", s_err, 0);
      run_s(8, 1'b0, dc, nb);
      chk("t6_mem_intact", s_pass, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
